// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with full/empty/threshold flags, sticky
//               overflow/underflow, flush, and standard or FWFT read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int address_bus_length  = 4,
    parameter int data_bus_length     = 8,
    parameter int almost_full_margin  = 2,
    parameter int almost_empty_margin = 2,
    parameter int fwft_mode           = 0
) (
    input  logic                          fifo_clk,
    input  logic                          fifo_rst,
    input  logic                          write_enable,
    input  logic [data_bus_length-1:0]    trans_data,
    input  logic                          read_enable,
    output logic [data_bus_length-1:0]    recv_data,
    input  logic                          fifo_flush,
    input  logic                          clear_flags,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [address_bus_length:0]   fill_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_depth    = 2 ** address_bus_length;
    localparam int c_af_level = c_depth - almost_full_margin;
    localparam int c_ae_level = almost_empty_margin;
    localparam logic [address_bus_length:0] c_depth_w = (address_bus_length + 1)'(c_depth);

    logic [data_bus_length-1:0]    mem_q [c_depth];
    logic [address_bus_length-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_bus_length-1:0] rd_ptr_q, rd_ptr_d;
    logic [address_bus_length:0]   count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          underflow_q, underflow_d;
    logic [data_bus_length-1:0]    rdata_q, rdata_d;
    logic                          w_rd_acc;
    logic                          w_wr_acc;
    logic                          w_mem_we;

    // A read needs stored data; a write may use the slot a same-cycle read frees.
    assign w_rd_acc = read_enable && (count_q != '0);
    assign w_wr_acc = write_enable && ((count_q != c_depth_w) || w_rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rdata_d     = rdata_q;
        w_mem_we    = 1'b0;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (clear_flags) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                w_mem_we = 1'b1;
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rdata_d  = mem_q[rd_ptr_q];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // A fresh error in the same cycle wins over a clear request.
            overflow_d  = (write_enable && !w_wr_acc) || (overflow_q && !clear_flags);
            underflow_d = (read_enable && !w_rd_acc) || (underflow_q && !clear_flags);
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (w_mem_we && !fifo_rst) begin
            mem_q[wr_ptr_q] <= trans_data;
        end
    end

    generate
        if (fwft_mode != 0) begin : g_fwft
            // Head word is visible as soon as the FIFO holds data; zero when empty.
            assign recv_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            assign recv_data = rdata_q;
        end
    endgenerate

    assign fill_level   = count_q;
    assign fifo_full    = (count_q == c_depth_w);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (32'(count_q) >= c_af_level);
    assign almost_empty = (32'(count_q) <= c_ae_level);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Randomised check of sync_fifo_flags (standard and FWFT
//               instances) against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       fifo_rst = 1'b1;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic       fifo_flush = 1'b0;
    logic       clear_flags = 1'b0;
    logic [7:0] trans_data = '0;

    logic [7:0] s_recv, f_recv;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [4:0] s_fill, f_fill;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q[$];
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;
    logic [7:0] m_rd0 = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.fwft_mode(0)) u_dut_std (
        .fifo_clk(clk), .fifo_rst(fifo_rst), .write_enable(write_enable),
        .trans_data(trans_data), .read_enable(read_enable), .recv_data(s_recv),
        .fifo_flush(fifo_flush), .clear_flags(clear_flags), .fifo_full(s_full),
        .fifo_empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .fill_level(s_fill), .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_flags #(.fwft_mode(1)) u_dut_fwft (
        .fifo_clk(clk), .fifo_rst(fifo_rst), .write_enable(write_enable),
        .trans_data(trans_data), .read_enable(read_enable), .recv_data(f_recv),
        .fifo_flush(fifo_flush), .clear_flags(clear_flags), .fifo_full(f_full),
        .fifo_empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .fill_level(f_fill), .overflow(f_ov), .underflow(f_un)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference behaviour expressed on a plain queue of words.
    task automatic model_edge(input logic rst, flush, clr, we, re, input logic [7:0] d);
        bit ra, wa;
        if (rst) begin
            m_q.delete();
            m_ov = 0; m_un = 0; m_rd0 = '0;
        end else if (flush) begin
            m_q.delete();
            if (clr) begin m_ov = 0; m_un = 0; end
        end else begin
            ra = re && (m_q.size() > 0);
            wa = we && (m_q.size() < 16 || ra);
            if (ra) m_rd0 = m_q.pop_front();
            if (wa) m_q.push_back(d);
            m_ov = (we && !wa) ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_un = (re && !ra) ? 1'b1 : (clr ? 1'b0 : m_un);
        end
    endtask

    task automatic compare_all();
        int n;
        n = m_q.size();
        check("fill_level", 32'(s_fill), 32'(n));
        check("fifo_full", 32'(s_full), 32'(n == 16));
        check("fifo_empty", 32'(s_empty), 32'(n == 0));
        check("almost_full", 32'(s_af), 32'(n >= 14));
        check("almost_empty", 32'(s_ae), 32'(n <= 2));
        check("overflow", 32'(s_ov), 32'(m_ov));
        check("underflow", 32'(s_un), 32'(m_un));
        check("recv_data_std", 32'(s_recv), 32'(m_rd0));
        check("fwft_fill", 32'(f_fill), 32'(n));
        check("fwft_empty", 32'(f_empty), 32'(n == 0));
        check("fwft_flags", {28'd0, f_full, f_af, f_ae, f_ov ^ f_un},
              {28'd0, 1'(n == 16), 1'(n >= 14), 1'(n <= 2), m_ov ^ m_un});
        check("recv_data_fwft", 32'(f_recv), (n > 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    task automatic step(input logic rst, flush, clr, we, re, input logic [7:0] d);
        fifo_rst = rst; fifo_flush = flush; clear_flags = clr;
        write_enable = we; read_enable = re; trans_data = d;
        @(posedge clk);
        model_edge(rst, flush, clr, we, re, d);
        #1;
        compare_all();
    endtask

    initial begin
        int wprob, rprob;
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        // Fill with 17..32, overflow, drain, clear.
        for (int i = 17; i <= 32; i++) step(0, 0, 0, 1, 0, 8'(i));
        step(0, 0, 0, 1, 0, 8'd99);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        // Refill, then write+read while full; 99 must drain last.
        for (int i = 17; i <= 32; i++) step(0, 0, 0, 1, 0, 8'(i));
        step(0, 0, 0, 1, 1, 8'd99);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 8'h00);
        // Underflow on empty, then write+read while empty.
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, 8'd5);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 8'hA5);
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'(i + 1));
        step(0, 1, 0, 1, 1, 8'h77);
        step(0, 0, 0, 0, 0, 8'h00);
        // Randomised phases with varying write/read pressure.
        wprob = 50; rprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                wprob = $urandom_range(10, 90);
                rprob = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) < wprob), ($urandom_range(0, 99) < rprob),
                 8'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter address_bus_length, default 4, meaning log2 of depth; DEPTH = 2**address_bus_length.
REQ-002 SHALL have parameter data_bus_length, default 8, meaning word width in bits.
REQ-003 SHALL have parameter almost_full_margin, default 2, meaning almost_full asserts when fill_level >= DEPTH - almost_full_margin.
REQ-004 SHALL have parameter almost_empty_margin, default 2, meaning almost_empty asserts when fill_level <= almost_empty_margin.
REQ-005 SHALL have parameter fwft_mode, default 0, meaning 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
 fifo_clk  in  1  single clock; all state updates on its rising edge
 fifo_rst  in  1  reset, synchronous, active-high
 write_enable  in  1  push request
 trans_data  in  data_bus_length  push data
 read_enable  in  1  pop request
 recv_data  out  data_bus_length  read data
 fifo_flush  in  1  synchronous empty command
 clear_flags  in  1  clears sticky error flags
 fifo_full  out  1  fill_level == DEPTH
 fifo_empty  out  1  fill_level == 0
 almost_full  out  1  threshold flag per REQ-003
 almost_empty  out  1  threshold flag per REQ-004
 fill_level  out  address_bus_length+1  current occupancy, 0..DEPTH
 overflow  out  1  sticky: a write was rejected
 underflow  out  1  sticky: a read was rejected

Function
REQ-007 Storage SHALL be DEPTH x data_bus_length; write and read pointers SHALL be address_bus_length bits and wrap from DEPTH-1 to 0.
REQ-008 A write SHALL be accepted when write_enable=1 and either fill_level<DEPTH or a read is accepted in the same cycle; trans_data is stored at the write pointer and the pointer increments.
REQ-009 A read SHALL be accepted when read_enable=1 and fill_level>0; a read while empty SHALL be rejected even if a write occurs in the same cycle.
REQ-010 fill_level SHALL be +1 on write only, -1 on read only, unchanged on both or neither.
REQ-011 All status outputs SHALL be derived from registered state only; no combinational path from write_enable/read_enable to any flag.
REQ-012 fwft_mode=0: on an accepted read, recv_data SHALL present the head word after that same edge (1-cycle latency) and hold otherwise.
REQ-013 fwft_mode=1: recv_data SHALL equal the head word whenever fifo_empty=0; an accepted read advances to the next word; a word written into an empty FIFO appears with fifo_empty deasserted one cycle after the write edge.
REQ-014 A rejected write SHALL set overflow; a rejected read SHALL set underflow; neither changes storage, pointers or fill_level.
REQ-015 clear_flags=1 SHALL clear overflow and underflow at the next edge; a new error event in the same cycle takes priority and sets the flag.
REQ-016 fifo_flush=1 SHALL zero both pointers and fill_level at the next edge, overriding any write/read that cycle; storage contents and sticky flags are not altered.
REQ-017 Priority at each edge: fifo_rst > fifo_flush > write/read.

Reset
REQ-018 fifo_rst=1 at an edge SHALL set pointers and fill_level to 0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0, recv_data=0.
REQ-019 Reset asserted mid-operation SHALL discard all queued words; storage need not be cleared.

Verification
REQ-020 Reset, write 17..32 on 16 consecutive edges -> fill_level=16, fifo_full=1; almost_full first asserts after the 14th write edge.
REQ-021 fwft_mode=0, read 16 consecutive cycles from full -> recv_data 17..32, each one edge after its read; fifo_empty=1, almost_empty=1 after last.
REQ-022 Full, write 99 without read -> overflow=1, fill_level=16, next reads return 17..32; clear_flags -> overflow=0.
REQ-023 Full, simultaneous write 99 and read -> fill_level stays 16, no overflow, 99 is the last word read out.
REQ-024 Empty, read only -> underflow=1, recv_data unchanged; empty, write 5 with read -> fill_level=1, underflow=1.
REQ-025 fwft_mode=1, write 0xA5 into empty -> next cycle fifo_empty=0, recv_data=0xA5 with read_enable=0; fifo_flush with 5 words queued -> fill_level=0, fifo_empty=1 next edge.
